// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative multiply/divide unit with architectural HI/LO registers.
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) one bit per cycle,
// services MTHI/MTLO while idle, and holds busy high until HI/LO are written.
module hilo_muldiv #(
   parameter int digit_number = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [1:0]              op,
   input  logic [digit_number-1:0] X,
   input  logic [digit_number-1:0] Y,
   input  logic                    mthi,
   input  logic                    mtlo,
   input  logic [digit_number-1:0] wdata,
   output logic                    busy,
   output logic                    done,
   output logic                    div_by_zero,
   output logic [digit_number-1:0] hi,
   output logic [digit_number-1:0] lo
);

   localparam int W  = digit_number;
   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } state_t;

   // Two's complement negate of a W-bit value.
   function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
      return ~v + {{(W-1){1'b0}}, 1'b1};
   endfunction

   // Two's complement negate of a 2W-bit value.
   function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
      return ~v + {{(2*W-1){1'b0}}, 1'b1};
   endfunction

   state_t          state_r, state_s;
   logic [1:0]      op_r;
   logic            q_sign_r, r_sign_r, div0_r;
   logic [CW-1:0]   cnt_r;
   logic [W-1:0]    opb_r;      // multiplicand (mul) or divisor (div)
   logic [2*W-1:0]  acc_r;      // product accumulator; low half holds dividend/quotient for div
   logic [W-1:0]    rem_r;      // partial remainder (always below the divisor)
   logic            busy_r, done_r, dz_r;
   logic [W-1:0]    hi_r, lo_r;

   logic [W-1:0]    x_mag_s, y_mag_s;
   logic            is_div_s, y_zero_s, last_s;
   logic [W:0]      mul_sum_s;
   logic [W:0]      shift_s;
   logic            ge_s;
   logic [W-1:0]    diff_s;
   logic [2*W-1:0]  prod_fix_s;
   logic [W-1:0]    quo_fix_s, rem_fix_s, dvd_fix_s;

   // Operand magnitudes, iteration arithmetic and sign-corrected results.
   always_comb begin
      x_mag_s    = (op[0] && X[W-1]) ? neg_w(X) : X;
      y_mag_s    = (op[0] && Y[W-1]) ? neg_w(Y) : Y;
      is_div_s   = op[1];
      y_zero_s   = (Y == {W{1'b0}});
      last_s     = (cnt_r == CW'(W-1));
      mul_sum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opb_r} : {(W+1){1'b0}});
      shift_s    = {rem_r, acc_r[W-1]};
      ge_s       = (shift_s >= {1'b0, opb_r});
      diff_s     = shift_s[W-1:0] - opb_r;
      prod_fix_s = q_sign_r ? neg_2w(acc_r) : acc_r;
      quo_fix_s  = q_sign_r ? neg_w(acc_r[W-1:0]) : acc_r[W-1:0];
      rem_fix_s  = r_sign_r ? neg_w(rem_r) : rem_r;
      // dividend is still untouched in the low half when dividing by zero
      dvd_fix_s  = r_sign_r ? neg_w(acc_r[W-1:0]) : acc_r[W-1:0];
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: IDLE -> CALC -> FIX -> IDLE, divide by zero skips CALC.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = (is_div_s && y_zero_s) ? ST_FIX : ST_CALC;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (last_s) begin
               state_s = ST_FIX;
            end else begin
               state_s = ST_CALC;
            end
         end
         ST_FIX:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, per-cycle iteration, result write-back and MTHI/MTLO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r     <= 2'b00;
         q_sign_r <= 1'b0;
         r_sign_r <= 1'b0;
         div0_r   <= 1'b0;
         cnt_r    <= {CW{1'b0}};
         opb_r    <= {W{1'b0}};
         acc_r    <= {(2*W){1'b0}};
         rem_r    <= {W{1'b0}};
         busy_r   <= 1'b0;
         hi_r     <= {W{1'b0}};
         lo_r     <= {W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  op_r     <= op;
                  q_sign_r <= op[0] & (X[W-1] ^ Y[W-1]);
                  r_sign_r <= op[0] & X[W-1];
                  div0_r   <= is_div_s & y_zero_s;
                  cnt_r    <= {CW{1'b0}};
                  busy_r   <= 1'b1;
                  rem_r    <= {W{1'b0}};
                  if (is_div_s) begin
                     opb_r <= y_mag_s;
                     acc_r <= {{W{1'b0}}, x_mag_s};
                  end else begin
                     opb_r <= x_mag_s;
                     acc_r <= {{W{1'b0}}, y_mag_s};
                  end
               end else begin
                  if (mthi) begin
                     hi_r <= wdata;
                  end
                  if (mtlo) begin
                     lo_r <= wdata;
                  end
               end
            end
            ST_CALC: begin
               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (op_r[1]) begin
                  if (ge_s) begin
                     rem_r <= diff_s;
                     acc_r <= {acc_r[2*W-1:W], acc_r[W-2:0], 1'b1};
                  end else begin
                     rem_r <= shift_s[W-1:0];
                     acc_r <= {acc_r[2*W-1:W], acc_r[W-2:0], 1'b0};
                  end
               end else begin
                  acc_r <= {mul_sum_s, acc_r[W-1:1]};
               end
            end
            ST_FIX: begin
               busy_r <= 1'b0;
               if (op_r[1]) begin
                  if (div0_r) begin
                     hi_r <= dvd_fix_s;
                     lo_r <= {W{1'b1}};
                  end else begin
                     hi_r <= rem_fix_s;
                     lo_r <= quo_fix_s;
                  end
               end else begin
                  hi_r <= prod_fix_s[2*W-1:W];
                  lo_r <= prod_fix_s[W-1:0];
               end
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   // Completion pulses, raised for the single cycle after HI/LO are written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_r <= 1'b0;
         dz_r   <= 1'b0;
      end else begin
         done_r <= (state_r == ST_FIX);
         dz_r   <= (state_r == ST_FIX) & div0_r;
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign div_by_zero = dz_r;
   assign hi          = hi_r;
   assign lo          = lo_r;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus pushes expected HI/LO/flag,
// a monitor pops and compares on every done pulse.
module tb_hilo_muldiv;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst, start, mthi, mtlo;
   logic [1:0]    op;
   logic [W-1:0]  X, Y, wdata;
   wire           busy, done, div_by_zero;
   wire  [W-1:0]  hi, lo;

   typedef struct {
      string        name;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;

   exp_t  sb[$];
   exp_t  mon_e;
   int    tests = 0;
   int    fails = 0;
   logic  prev_done = 1'b0;

   hilo_muldiv #(.digit_number(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .X(X), .Y(Y),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare against the scoreboard on each done pulse.
   always @(negedge clk) begin
      if (!rst && done) begin
         check("done_single_cycle", {31'b0, prev_done}, 32'd0);
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected no pending op");
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, " hi"}, hi, mon_e.hi);
            check({mon_e.name, " lo"}, lo, mon_e.lo);
            check({mon_e.name, " dz"}, {31'b0, div_by_zero}, {31'b0, mon_e.dz});
         end
      end else if (!rst && div_by_zero) begin
         check("dz_without_done", {31'b0, div_by_zero}, 32'd0);
      end
      prev_done <= done;
   end

   task automatic wait_idle(input string name, input int ecyc, input int inj_at, input int rst_at);
      int n;
      n = 0;
      while (busy && n < 200) begin
         if (n == inj_at) begin
            start = 1'b1; op = 2'b10; X = 32'd9; Y = 32'd3;
            mthi = 1'b1; wdata = 32'h0000_DEAD;
         end
         tick();
         start = 1'b0;
         mthi  = 1'b0;
         n++;
         if (n == rst_at) begin
            rst = 1'b1;
            #1;
            check({name, " rst hi"}, hi, 32'd0);
            check({name, " rst lo"}, lo, 32'd0);
            check({name, " rst busy"}, {31'b0, busy}, 32'd0);
            check({name, " rst done"}, {31'b0, done}, 32'd0);
            rst = 1'b0;
            return;
         end
      end
      check({name, " busy_cycles"}, n, ecyc);
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic edz, input int ecyc, input int inj_at, input int rst_at);
      if (rst_at < 0) sb.push_back('{name, ehi, elo, edz});
      op = o; X = x; Y = y; start = 1'b1;
      tick();
      start = 1'b0;
      X = 32'h5A5A_A5A5;
      Y = 32'hC3C3_3C3C;
      check({name, " busy_after_start"}, {31'b0, busy}, 32'd1);
      wait_idle(name, ecyc, inj_at, rst_at);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      op = 2'b00; X = '0; Y = '0; wdata = '0;
      tick();
      tick();
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset dz", {31'b0, div_by_zero}, 32'd0);
      rst = 1'b0;
      tick();

      // MTHI then MTLO on consecutive cycles
      mthi = 1'b1; wdata = 32'h0000_AAAA;
      tick();
      mthi = 1'b0; mtlo = 1'b1; wdata = 32'h0000_5555;
      tick();
      mtlo = 1'b0;
      check("mthi hi", hi, 32'h0000_AAAA);
      check("mtlo lo", lo, 32'h0000_5555);

      // MTHI and MTLO together
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_003C;
      tick();
      mthi = 1'b0; mtlo = 1'b0;
      check("mthi_mtlo hi", hi, 32'h0000_003C);
      check("mthi_mtlo lo", lo, 32'h0000_003C);

      // MTHI together with start: move dropped, op taken
      sb.push_back('{"mv_start", 32'd0, 32'd6, 1'b0});
      mthi = 1'b1; wdata = 32'h0000_7777; start = 1'b1; op = 2'b00; X = 32'd2; Y = 32'd3;
      tick();
      mthi = 1'b0; start = 1'b0;
      check("mv_start hi_unchanged", hi, 32'h0000_003C);
      check("mv_start busy", {31'b0, busy}, 32'd1);
      wait_idle("mv_start", 33, -1, -1);

      // directed arithmetic vectors (each new start lands in the previous done cycle)
      run_op("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, -1, -1);
      run_op("mult_m3x7",  2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, -1, -1);
      run_op("mult_m5xm6", 2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, 1'b0, 33, -1, -1);
      run_op("mult_min2",  2'b01, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33, -1, -1);
      run_op("multu_2p32", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 33, -1, -1);
      run_op("div_m7d2",   2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, -1, -1);
      run_op("div_7dm2",   2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33, -1, -1);
      run_op("divu_7d2",   2'b10, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 1'b0, 33, -1, -1);
      run_op("divu_100d7", 2'b10, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 33, -1, -1);
      run_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, -1, -1);
      run_op("divu_by0",   2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1,  -1, -1);
      run_op("div_m8by0",  2'b11, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 1,  -1, -1);

      // start + mthi mid-op are ignored
      run_op("mid_inject", 2'b00, 32'h0000_1234, 32'h0000_0010, 32'h0000_0000, 32'h0001_2340, 1'b0, 33, 10, -1);
      tick();
      // async reset in the middle of an op
      run_op("mid_reset",  2'b00, 32'h0000_1234, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0, 33, -1, 20);
      tick();
      run_op("after_rst",  2'b00, 32'd5,         32'd6,         32'h0000_0000, 32'h0000_001E, 1'b0, 33, -1, -1);

      tick();
      tick();
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
